// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  mux_ctrl_pkg
//  Shared sizes, FSM state type and one-hot decode for the 4:1 mux arbiter.
//  Revision: 1.0
// ============================================================================
package mux_ctrl_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  mux4_rr_arbiter_if
//  Request/grant and mux-select bundle between requesters and the arbiter.
//  Revision: 1.0
// ============================================================================
interface mux4_rr_arbiter_if;
  import mux_ctrl_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               s0;
  logic               s1;
  logic               sel_valid;

  modport master (
    output req,
    input  grant,
    input  s0,
    input  s1,
    input  sel_valid
  );

  modport slave (
    input  req,
    output grant,
    output s0,
    output s1,
    output sel_valid
  );

endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
//  rr_pick4
//  Combinational circular search: first set request at or after i_start.
//  Revision: 1.0
// ============================================================================
module rr_pick4
  import mux_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_start,
  output logic               o_found,
  output logic [SEL_W-1:0]   o_idx
);

  logic [SEL_W-1:0] w_pos;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    w_pos   = i_start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = i_start + SEL_W'(k);
      if (i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  mux4_rr_arbiter
//  Round-robin owner selection for a 4:1 mux with bounded bursts under contention.
//  Revision: 1.0
// ============================================================================
module mux4_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 4
)
(
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] c_max_burst = CNT_W'(MAX_BURST);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic               r_valid;
  logic               w_valid_nxt;

  logic [SEL_W-1:0]   w_owner;
  logic [NUM_REQ-1:0] w_others;
  logic [SEL_W-1:0]   w_handoff_start;
  logic               w_release;
  logic               w_idle_found;
  logic [SEL_W-1:0]   w_idle_idx;
  logic               w_hand_found;
  logic [SEL_W-1:0]   w_hand_idx;

  assign w_owner         = onehot2idx(r_grant);
  assign w_others        = bus.req & ~r_grant;
  assign w_handoff_start = w_owner + SEL_W'(1);
  assign w_release       = !bus.req[w_owner] || ((r_cnt == c_max_burst) && (|w_others));

  rr_pick4 u_pick_idle (
    .i_req   (bus.req),
    .i_start (r_ptr),
    .o_found (w_idle_found),
    .o_idx   (w_idle_idx)
  );

  // Handoff search excludes the current owner and starts just past it.
  rr_pick4 u_pick_handoff (
    .i_req   (w_others),
    .i_start (w_handoff_start),
    .o_found (w_hand_found),
    .o_idx   (w_hand_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_idle_found) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = NUM_REQ'(1) << w_idle_idx;
          w_sel_nxt   = w_idle_idx;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_handoff_start;
          if (w_hand_found) begin
            w_grant_nxt = NUM_REQ'(1) << w_hand_idx;
            w_sel_nxt   = w_hand_idx;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            // Select lines keep the last owner so the mux output stays stable.
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end
        end else if (r_cnt != c_max_burst) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.grant     = r_grant;
  assign bus.s0        = r_sel[0];
  assign bus.s1        = r_sel[1];
  assign bus.sel_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_mux4_rr_arbiter
//  Self-checking bench: two arbiters (MAX_BURST 4 and 1) against a queue-free model.
//  Revision: 1.0
// ============================================================================
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst_n;

  mux4_rr_arbiter_if bus4 ();
  mux4_rr_arbiter_if bus1 ();

  mux4_rr_arbiter #(.MAX_BURST(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux4_rr_arbiter #(.MAX_BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: owner index (-1 idle), priority pointer, burst length, select.
  int mb      [2] = '{4, 1};
  int m_owner [2];
  int m_ptr   [2];
  int m_burst [2];
  int m_sel   [2];
  logic [3:0] prev_g [2];
  int         run    [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input logic rst, input logic [3:0] r);
    int  g;
    int  i;
    bit  found;
    bit  contend;
    found = 1'b0;
    if (!rst) begin
      m_owner[d] = -1; m_ptr[d] = 0; m_burst[d] = 0; m_sel[d] = 0;
    end else if (m_owner[d] < 0) begin
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr[d] + k) % 4;
        if (!found && r[i]) begin
          found = 1'b1; m_owner[d] = i; m_sel[d] = i; m_burst[d] = 1;
        end
      end
    end else begin
      g = m_owner[d];
      contend = 1'b0;
      for (int k = 0; k < 4; k++) if (k != g && r[k]) contend = 1'b1;
      if (!r[g] || (m_burst[d] == mb[d] && contend)) begin
        m_ptr[d] = (g + 1) % 4;
        for (int k = 1; k < 4; k++) begin
          i = (g + k) % 4;
          if (!found && r[i]) begin
            found = 1'b1; m_owner[d] = i; m_sel[d] = i; m_burst[d] = 1;
          end
        end
        if (!found) m_owner[d] = -1;
      end else if (m_burst[d] < mb[d]) begin
        m_burst[d] = m_burst[d] + 1;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [3:0] g, input logic [1:0] sel,
                           input logic v, input logic rst, input logic [3:0] r);
    logic [3:0] eg;
    logic [1:0] gi;
    bit         viol;
    eg = (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
    gi = 2'b00;
    for (int k = 0; k < 4; k++) if (g[k]) gi = 2'(k);
    chk($sformatf("mb%0d grant", mb[d]), 32'(g), 32'(eg));
    chk($sformatf("mb%0d sel", mb[d]), 32'(sel), 32'(m_sel[d]));
    chk($sformatf("mb%0d sel_valid", mb[d]), 32'(v), 32'(m_owner[d] >= 0));
    chk($sformatf("mb%0d onehot0", mb[d]), 32'($onehot0(g)), 32'd1);
    chk($sformatf("mb%0d valid_eq_or", mb[d]), 32'(v), 32'(|g));
    if (v) chk($sformatf("mb%0d sel_eq_idx", mb[d]), 32'(sel), 32'(gi));
    viol = rst && (g != 4'b0) && (g == prev_g[d]) && (run[d] >= mb[d]) && ((r & ~g) != 4'b0);
    chk($sformatf("mb%0d burst_bound", mb[d]), 32'(viol), 32'd0);
    if (!rst || g == 4'b0) run[d] = 0;
    else if (g == prev_g[d]) run[d] = run[d] + 1;
    else run[d] = 1;
    prev_g[d] = g;
  endtask

  task automatic cycle(input logic rst, input logic [3:0] r);
    rst_n    = rst;
    bus4.req = r;
    bus1.req = r;
    @(posedge clk);
    model_step(0, rst, r);
    model_step(1, rst, r);
    #1;
    check_dut(0, bus4.grant, {bus4.s1, bus4.s0}, bus4.sel_valid, rst, r);
    check_dut(1, bus1.grant, {bus1.s1, bus1.s0}, bus1.sel_valid, rst, r);
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
  } tvec_t;

  tvec_t tv [12];

  initial begin
    logic [3:0] r;
    logic       rs;
    tv[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    tv[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    tv[2]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    tv[3]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tv[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tv[5]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
    tv[6]  = '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1};
    tv[7]  = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tv[8]  = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
    tv[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0};
    tv[10] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tv[11] = '{1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1};

    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_ptr[d] = 0; m_burst[d] = 0; m_sel[d] = 0;
      prev_g[d] = 4'b0; run[d] = 0;
    end
    rst_n = 1'b0; bus4.req = 4'b0; bus1.req = 4'b0;
    @(negedge clk);

    // Reset, single request, early handoff, return to idle.
    for (int i = 0; i < 12; i++) begin
      cycle(tv[i].rst, tv[i].req);
      chk($sformatf("vec%0d grant", i), 32'(bus4.grant), 32'(tv[i].grant));
      chk($sformatf("vec%0d sel", i), 32'({bus4.s1, bus4.s0}), 32'(tv[i].sel));
      chk($sformatf("vec%0d valid", i), 32'(bus4.sel_valid), 32'(tv[i].valid));
    end

    // Full contention: rotation every 4 cycles (MAX_BURST=4) and every cycle (MAX_BURST=1).
    cycle(1'b0, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 4'b1111);
      chk($sformatf("rot4 c%0d", k), 32'(bus4.grant), 32'(4'b0001 << ((k / 4) % 4)));
      chk($sformatf("rot1 c%0d", k), 32'(bus1.grant), 32'(4'b0001 << (k % 4)));
    end

    // Saturated lone owner keeps the channel until a contender appears.
    cycle(1'b0, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 4'b0001);
      chk($sformatf("sat4 c%0d", k), 32'(bus4.grant), 32'h1);
    end
    cycle(1'b1, 4'b0101);
    chk("sat4 handoff", 32'(bus4.grant), 32'h4);
    chk("sat1 handoff", 32'(bus1.grant), 32'h4);

    // Reset in the middle of a burst clears owner, selects and pointer.
    cycle(1'b0, 4'b0000);
    cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b0100);
    chk("midrst pre grant", 32'(bus4.grant), 32'h4);
    cycle(1'b0, 4'b0100);
    chk("midrst grant", 32'(bus4.grant), 32'h0);
    chk("midrst sel", 32'({bus4.s1, bus4.s0}), 32'h0);
    cycle(1'b1, 4'b1111);
    chk("midrst regrant", 32'(bus4.grant), 32'h1);

    // Randomized traffic with held requests and occasional resets.
    r = 4'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) != 0) r = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 59) != 0);
      cycle(rs, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
